// File: rtl/alert_handler_esc_timer_accu.sv
// alert_handler_esc_timer_accu: per-class alert accumulator and irq timeout escalation trigger (timeout path enabled by ALERT_HANDLER_TIMEOUT_EN)
module alert_handler_esc_timer_accu #(
  parameter int AccuCntDw    = 16,
  parameter int TimeoutCntDw = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    class_trig_i,
  input  logic                    class_en_i,
  input  logic                    clr_i,
  input  logic                    irq_pending_i,
  input  logic [AccuCntDw-1:0]    accu_thresh_i,
  input  logic [TimeoutCntDw-1:0] timeout_cyc_i,
  output logic [AccuCntDw-1:0]    accu_cnt_o,
  output logic [TimeoutCntDw-1:0] timeout_cnt_o,
  output logic                    accu_trig_o,
  output logic                    timeout_trig_o,
  output logic                    esc_trig_o,
  output logic [1:0]              state_o
);
  typedef enum logic [1:0] {Idle = 2'b00, Timeout = 2'b01, Esc = 2'b10} state_e;
  state_e state_q, state_d;
  logic ev, accu_hit, to_hit, esc;
  logic [AccuCntDw-1:0] accu_d;
  assign ev       = class_en_i & class_trig_i;
  assign accu_hit = ev & (accu_cnt_o >= accu_thresh_i);
  assign accu_d   = clr_i ? '0 : (ev && !(&accu_cnt_o)) ? accu_cnt_o + 1'b1 : accu_cnt_o;
  assign state_o  = state_q;
`ifdef ALERT_HANDLER_TIMEOUT_EN
  logic [TimeoutCntDw-1:0] cnt_d;
  logic [TimeoutCntDw:0] cnt_inc;
  logic to_stay, to_arm;
  assign cnt_inc = {1'b0, timeout_cnt_o} + 1'b1;
  assign to_stay = irq_pending_i & class_en_i;
  assign to_arm  = to_stay & (timeout_cyc_i != '0);
  // next state, timeout counter and trigger decode; clear overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = timeout_cnt_o;
    to_hit  = 1'b0;
    esc     = 1'b0;
    case (state_q)
      Idle: begin
        if (accu_hit) begin
          state_d = Esc;
          esc     = 1'b1;
        end else if (to_arm) begin
          state_d = Timeout;
          cnt_d   = '0;
        end
      end
      Timeout: begin
        to_hit = to_stay && (cnt_inc >= {1'b0, timeout_cyc_i});
        if (to_stay) cnt_d = &timeout_cnt_o ? timeout_cnt_o : cnt_inc[TimeoutCntDw-1:0];
        if (accu_hit || to_hit) begin
          state_d = Esc;
          esc     = 1'b1;
        end else if (!to_stay) begin
          state_d = Idle;
          cnt_d   = '0;
        end
      end
      Esc: state_d = Esc;
      default: begin
        state_d = Esc;
        esc     = 1'b1;
      end
    endcase
    if (clr_i) begin
      state_d = Idle;
      cnt_d   = '0;
    end
  end
  // timeout counter and its trigger pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_cnt_o  <= '0;
      timeout_trig_o <= 1'b0;
    end else begin
      timeout_cnt_o  <= cnt_d;
      timeout_trig_o <= to_hit & ~clr_i;
    end
  end
`else
  logic unused_to;
  assign unused_to      = ^{irq_pending_i, timeout_cyc_i};
  assign timeout_cnt_o  = '0;
  assign timeout_trig_o = 1'b0;
  // next state without a timeout path; any non-Idle/Esc encoding fails safe into Esc
  always_comb begin
    state_d = state_q;
    to_hit  = 1'b0;
    esc     = 1'b0;
    case (state_q)
      Idle: begin
        state_d = accu_hit ? Esc : Idle;
        esc     = accu_hit;
      end
      Esc: state_d = Esc;
      default: begin
        state_d = Esc;
        esc     = 1'b1;
      end
    endcase
    if (clr_i) state_d = Idle;
  end
`endif
  // state, accumulator and trigger pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      accu_cnt_o  <= '0;
      accu_trig_o <= 1'b0;
      esc_trig_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      accu_cnt_o  <= accu_d;
      accu_trig_o <= accu_hit & ~clr_i;
      esc_trig_o  <= esc & ~clr_i;
    end
  end
endmodule

// File: tb/tb_alert_handler_esc_timer_accu.sv
// tb_alert_handler_esc_timer_accu: directed scoreboard bench for the escalation timer/accumulator
module tb_alert_handler_esc_timer_accu;
  logic clk_i = 1'b0;
  logic rst_i, class_trig_i, class_en_i, clr_i, irq_pending_i;
  logic [15:0] accu_thresh_i;
  logic [3:0] sat_thresh;
  logic [31:0] timeout_cyc_i;
  logic [15:0] accu_cnt_o;
  logic [31:0] timeout_cnt_o, sat_tcnt;
  logic accu_trig_o, timeout_trig_o, esc_trig_o;
  logic [1:0] state_o, sat_st;
  logic [3:0] sat_cnt;
  logic sat_at, sat_tt, sat_et;
  typedef struct {
    string tag;
    logic [15:0] accu;
    logic [31:0] tc;
    logic at, tt, et;
    logic [1:0] st;
    logic sc;
    logic [3:0] sa;
    logic se;
  } exp_t;
  exp_t sb[$];
  int vecs = 0, errs = 0;
  logic sat_chk;
  logic [3:0] sat_accu;
  logic sat_esc;

  always #5 clk_i = ~clk_i;

  alert_handler_esc_timer_accu u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .class_trig_i(class_trig_i), .class_en_i(class_en_i),
    .clr_i(clr_i), .irq_pending_i(irq_pending_i), .accu_thresh_i(accu_thresh_i),
    .timeout_cyc_i(timeout_cyc_i), .accu_cnt_o(accu_cnt_o), .timeout_cnt_o(timeout_cnt_o),
    .accu_trig_o(accu_trig_o), .timeout_trig_o(timeout_trig_o), .esc_trig_o(esc_trig_o),
    .state_o(state_o)
  );

  alert_handler_esc_timer_accu #(.AccuCntDw(4)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .class_trig_i(class_trig_i), .class_en_i(class_en_i),
    .clr_i(clr_i), .irq_pending_i(irq_pending_i), .accu_thresh_i(sat_thresh),
    .timeout_cyc_i(timeout_cyc_i), .accu_cnt_o(sat_cnt), .timeout_cnt_o(sat_tcnt),
    .accu_trig_o(sat_at), .timeout_trig_o(sat_tt), .esc_trig_o(sat_et),
    .state_o(sat_st)
  );

  task automatic step(input logic r, en, tr, cl, irq, input string tag,
                      input logic [15:0] accu, input logic [31:0] tc,
                      input logic at, tt, et, input logic [1:0] st);
    exp_t e, g;
    @(negedge clk_i);
    rst_i = r; class_en_i = en; class_trig_i = tr; clr_i = cl; irq_pending_i = irq;
    e.tag = tag; e.accu = accu; e.tc = tc; e.at = at; e.tt = tt; e.et = et; e.st = st;
    e.sc = sat_chk; e.sa = sat_accu; e.se = sat_esc;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    g = sb.pop_front();
    vecs++;
    assert (accu_cnt_o === g.accu) else begin errs++; $error("FAIL %s accu_cnt got %0d want %0d", g.tag, accu_cnt_o, g.accu); end
    assert (timeout_cnt_o === g.tc) else begin errs++; $error("FAIL %s timeout_cnt got %0d want %0d", g.tag, timeout_cnt_o, g.tc); end
    assert (accu_trig_o === g.at) else begin errs++; $error("FAIL %s accu_trig got %b want %b", g.tag, accu_trig_o, g.at); end
    assert (timeout_trig_o === g.tt) else begin errs++; $error("FAIL %s timeout_trig got %b want %b", g.tag, timeout_trig_o, g.tt); end
    assert (esc_trig_o === g.et) else begin errs++; $error("FAIL %s esc_trig got %b want %b", g.tag, esc_trig_o, g.et); end
    assert (state_o === g.st) else begin errs++; $error("FAIL %s state got %b want %b", g.tag, state_o, g.st); end
    if (g.sc) begin
      assert (sat_cnt === g.sa) else begin errs++; $error("FAIL %s sat_accu got %0d want %0d", g.tag, sat_cnt, g.sa); end
      assert (sat_et === g.se) else begin errs++; $error("FAIL %s sat_esc got %b want %b", g.tag, sat_et, g.se); end
    end
  endtask

  initial begin
    rst_i = 1'b1; class_trig_i = 1'b0; class_en_i = 1'b0; clr_i = 1'b0; irq_pending_i = 1'b0;
    accu_thresh_i = 16'd2; sat_thresh = 4'd15; timeout_cyc_i = 32'd0;
    sat_chk = 1'b0; sat_accu = 4'd0; sat_esc = 1'b0;
    step(1, 0, 0, 0, 0, "reset",    0, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 0, 0, "accu_ev1", 1, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 0, 0, "accu_ev2", 2, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 0, 0, "accu_ev3", 3, 0, 1, 0, 1, 2'b10);
    step(0, 0, 0, 0, 0, "esc_hold", 3, 0, 0, 0, 0, 2'b10);
    step(0, 1, 1, 0, 0, "esc_accu", 4, 0, 1, 0, 0, 2'b10);
    step(0, 0, 0, 0, 0, "esc_dis",  4, 0, 0, 0, 0, 2'b10);
    step(0, 1, 1, 1, 0, "clr_ev",   0, 0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 0, "post_clr", 0, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 0, 0, "re_ev1",   1, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 0, 0, "re_ev2",   2, 0, 0, 0, 0, 2'b00);
    step(0, 1, 1, 0, 0, "re_ev3",   3, 0, 1, 0, 1, 2'b10);
    step(1, 1, 1, 1, 1, "rst_mid",  0, 0, 0, 0, 0, 2'b00);
    timeout_cyc_i = 32'd3;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 1, "disabled", 0, 0, 0, 0, 0, 2'b00);
`ifdef ALERT_HANDLER_TIMEOUT_EN
    step(1, 0, 0, 0, 0, "to_reset", 0, 0, 0, 0, 0, 2'b00);
    step(0, 1, 0, 0, 1, "to_e0",    0, 0, 0, 0, 0, 2'b01);
    step(0, 1, 0, 0, 1, "to_e1",    0, 1, 0, 0, 0, 2'b01);
    step(0, 1, 0, 0, 1, "to_e2",    0, 2, 0, 0, 0, 2'b01);
    step(0, 1, 0, 0, 1, "to_e3",    0, 3, 0, 1, 1, 2'b10);
    step(0, 1, 0, 0, 1, "to_hold",  0, 3, 0, 0, 0, 2'b10);
    step(1, 0, 0, 0, 0, "to_reset2", 0, 0, 0, 0, 0, 2'b00);
    step(0, 1, 0, 0, 1, "drop_e0",  0, 0, 0, 0, 0, 2'b01);
    step(0, 1, 0, 0, 1, "drop_e1",  0, 1, 0, 0, 0, 2'b01);
    step(0, 1, 0, 0, 0, "drop_e2",  0, 0, 0, 0, 0, 2'b00);
    step(0, 1, 0, 0, 0, "drop_e3",  0, 0, 0, 0, 0, 2'b00);
`else
    step(1, 0, 0, 0, 0, "noto_reset", 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1, "noto_irq", 0, 0, 0, 0, 0, 2'b00);
`endif
    timeout_cyc_i = 32'd0;
    accu_thresh_i = 16'd100;
    sat_chk = 1'b1;
    step(1, 0, 0, 0, 0, "sat_reset", 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      sat_accu = (i >= 14) ? 4'd15 : 4'(i + 1);
      sat_esc = (i == 15);
      step(0, 1, 1, 0, 0, "sat", 16'(i + 1), 0, 0, 0, 0, 2'b00);
    end
    sat_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alert_handler_esc_timer_accu.md
# alert_handler_esc_timer_accu

Per-class escalation trigger stage, instantiated once per class directly downstream of the alert classifier. Consumes one bit of the classifier's per-class trigger vector, accumulates enabled alert events against a software threshold, and runs an interrupt-timeout counter while the class interrupt stays unacknowledged. Emits a single escalation-trigger pulse to the escalation protocol stage when either condition fires, then locks until software clears the class.

## Interface
- AccuCntDw, 16, accumulator width
- TimeoutCntDw, 32, timeout counter width

- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- class_trig_i  in  1  class trigger from classifier (one class bit)
- class_en_i  in  1  class enable
- clr_i  in  1  software class clear, single-cycle pulse
- irq_pending_i  in  1  class interrupt state bit (unacknowledged)
- accu_thresh_i  in  AccuCntDw  accumulation threshold
- timeout_cyc_i  in  TimeoutCntDw  interrupt timeout in cycles; 0 disables timeout
- accu_cnt_o  out  AccuCntDw  accumulator value (registered)
- timeout_cnt_o  out  TimeoutCntDw  timeout counter value (registered)
- accu_trig_o  out  1  accumulation threshold hit, 1-cycle pulse
- timeout_trig_o  out  1  timeout expired, 1-cycle pulse
- esc_trig_o  out  1  escalation trigger, 1-cycle pulse
- state_o  out  2  FSM state: Idle 2'b00, Timeout 2'b01, Esc 2'b10

## Operation
- Event = class_en_i & class_trig_i.
- Accumulator: each event increments accu_cnt by 1. Saturates at all-ones, no wrap. Counts in every state, including Esc.
- Accu hit = event & (accu_cnt_q >= accu_thresh_i). The count is the pre-increment value, so thresh=0 fires on the first event and thresh=N fires on the (N+1)th event.
- FSM:
  - Idle -> Timeout: irq_pending_i & class_en_i & (timeout_cyc_i != 0). timeout_cnt loads 0.
  - Timeout: if cnt_q+1 >= timeout_cyc_i, timeout hit and go to Esc; else cnt increments.
  - Timeout -> Idle: irq_pending_i low or class_en_i low. cnt clears to 0.
  - Idle/Timeout -> Esc: accu hit or timeout hit. Accu hit has priority when both occur; both trig outputs still pulse.
  - Esc: locked. No further esc/timeout pulses. timeout_cnt holds. accu_trig_o may still pulse on later hits. class_en_i low does not leave Esc.
  - Illegal encoding 2'b11 -> Esc, with an esc_trig_o pulse (fail-safe).
- esc_trig_o pulses once, on the transition into Esc.
- clr_i: from any state, next state is Idle and both counters become 0. It dominates every same-cycle event, so no trigger pulses occur in the following cycle.
- timeout_cnt saturates at all-ones.

## Timing
- Reset: state Idle, all counters and outputs 0.
- All outputs are registered. An event or condition sampled at edge N is visible after edge N (1-cycle latency).
- Timeout: irq_pending_i first sampled high at edge 0 gives Timeout state after edge 0. timeout_trig_o and esc_trig_o are high in the cycle after edge timeout_cyc_i, i.e. timeout_cyc_i+1 cycles of latency.
- Accu path: the hitting event at edge N gives accu_trig_o, esc_trig_o and state Esc after edge N.
- Reset mid-operation: synchronous reset has priority over clr_i and all events; outputs return to reset values after the edge.

## Configuration
- ALERT_HANDLER_TIMEOUT_EN defined: the timeout counter and Timeout state exist as described.
- Not defined:
  - Timeout state is unreachable and timeout_cnt is not implemented.
  - timeout_cnt_o and timeout_trig_o are tied to 0; irq_pending_i and timeout_cyc_i are ignored.
  - Escalation occurs only via the accumulator.

## Test plan
- Accumulator threshold: thresh=2, three single events on consecutive cycles. Required: accu_cnt_o 1,2,3; accu_trig_o and esc_trig_o pulse once, on the third event; state_o=2'b10.
- Timeout: macro defined, timeout_cyc_i=3, irq_pending_i held high from edge 0. Required: esc_trig_o high exactly one cycle, after edge 3. Deasserting irq_pending_i at edge 2 instead gives Idle, timeout_cnt_o=0 and no trigger.
- Saturation: AccuCntDw=4, thresh=15, 20 events. Required: accu_cnt_o sticks at 15; escalation fires on the 16th event only.
- Clear priority: in Esc, pulse clr_i together with an event. Required: state_o=0, accu_cnt_o=0, no pulses next cycle.
- Disabled class: class_en_i=0 with triggers and irq pending for 10 cycles. Required: counters 0, state Idle, no pulses. Repeat with macro undefined and irq pending: timeout_trig_o never asserts.
